// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - multi-cycle request/response initiator for the combinational ULA
//
// Takes one operation per request handshake, drives the ULA and returns the
// registered result over a response handshake. Shift opcodes (LSL, ASR) move
// one bit per ULA pass, so they are iterated req_shamt times.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op/req_a/req_b         ULA opcode and operands, sampled at acceptance
//   req_shamt                  shift count, used only for LSL/ASR
//   ula_a/ula_b/ula_opcode     registered drive towards the ULA
//   ula_out/ula_flag           combinational ULA result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_flag          result and flag of the final ULA pass
//   busy                       high whenever the FSM is not idle
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CW-1:0]    req_shamt,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [4:0]       ula_opcode,
    input  logic [WIDTH-1:0] ula_out,
    input  logic             ula_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic             busy
);

    localparam logic [4:0] OP_LSL  = 5'b01000;
    localparam logic [4:0] OP_ASR  = 5'b01001;
    localparam logic [4:0] OP_ZERO = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t           state_q,      state_d;
    logic [4:0]       op_q,         op_d;
    logic [WIDTH-1:0] acc_q,        acc_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             rsp_flag_q,   rsp_flag_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             req_ready_q,  req_ready_d;
    logic             busy_q,       busy_d;
    logic [WIDTH-1:0] ula_a_q,      ula_a_d;
    logic [WIDTH-1:0] ula_b_q,      ula_b_d;
    logic [4:0]       ula_opcode_q, ula_opcode_d;

    logic             rsp_done;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_LSL) || (op == OP_ASR);
    endfunction

    // rsp_valid trails entry into RESP by one cycle, so the handshake is
    // only seen once rsp_valid has actually been presented.
    assign rsp_done = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_flag_d = rsp_flag_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    acc_d = req_a;
                    b_d   = req_b;
                    cnt_d = req_shamt;
                    if (is_shift(req_op)) begin
                        if (req_shamt == '0) begin
                            // Zero-length shift: result is A, ULA never used.
                            rsp_data_d = req_a;
                            rsp_flag_d = 1'b0;
                            state_d    = S_RESP;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                rsp_data_d = ula_out;
                rsp_flag_d = ula_flag;
                state_d    = S_RESP;
            end
            S_SHIFT: begin
                acc_d = ula_out;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_data_d = ula_out;
                    rsp_flag_d = ula_flag;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rsp_valid_d = (state_q == S_RESP) && !rsp_done;
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);

        // ULA drive follows the next state so it is valid for exactly the
        // cycles spent in EXEC/SHIFT and parked at "Out=0" otherwise.
        ula_a_d      = '0;
        ula_b_d      = '0;
        ula_opcode_d = OP_ZERO;
        if (state_d == S_EXEC) begin
            ula_a_d      = acc_d;
            ula_b_d      = b_d;
            ula_opcode_d = op_d;
        end else if (state_d == S_SHIFT) begin
            ula_a_d      = acc_d;
            ula_b_d      = b_d;
            ula_opcode_d = op_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            acc_q        <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_flag_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_opcode_q <= OP_ZERO;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_opcode_q <= ula_opcode_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = busy_q;
    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_opcode = ula_opcode_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - scoreboard testbench for ula_seq with a behavioural ULA
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [31:0] ula_a;
    logic [31:0] ula_b;
    logic [4:0]  ula_opcode;
    logic [31:0] ula_out;
    logic        ula_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_flag;
    logic        busy;

    int passed = 0;
    int total  = 0;
    logic [32:0] sb_q[$];

    ula_seq #(.WIDTH(32), .CW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_opcode (ula_opcode),
        .ula_out    (ula_out),
        .ula_flag   (ula_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ULA: one-bit shifts per pass, flag = zero result.
    always_comb begin
        case (ula_opcode)
            5'b00000: ula_out = ula_a + ula_b;
            5'b01000: ula_out = ula_a << 1;
            5'b01001: ula_out = $signed(ula_a) >>> 1;
            5'b10110: ula_out = ula_a ^ ula_b;
            default:  ula_out = 32'h0;
        endcase
        ula_flag = (ula_out == 32'h0);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    // Monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e[32:1]);
                check("rsp_flag", {31'd0, rsp_flag}, {31'd0, e[0]});
            end
        end
    end

    task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] ed, input logic ef,
                         input int el, input int eoc, input int bp);
        int n;
        int oc;
        sb_q.push_back({ed, ef});
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_shamt = sh;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        check({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 5'b10110;
        req_a     = ~a;
        req_b     = $urandom;
        req_shamt = ~sh;
        n  = 0;
        oc = 0;
        while (1) begin
            @(negedge clk);
            if (rsp_valid || n >= 64) break;
            if (ula_opcode == op) oc++;
            @(posedge clk);
            n++;
        end
        check({nm, "_latency"}, n, el);
        check({nm, "_ula_op_cycles"}, oc, eoc);
        if (bp > 0) begin
            for (int i = 1; i < bp; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({nm, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({nm, "_bp_data"}, rsp_data, ed);
                check({nm, "_bp_req_ready"}, {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            check({nm, "_hs_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check({nm, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = 5'b00000;
        req_a     = 32'd7;
        req_b     = 32'd7;
        req_shamt = 5'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_flag", {31'd0, rsp_flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ula_opcode", {27'd0, ula_opcode}, 32'h10);
        check("rst_ula_a", ula_a, 32'd0);
        check("rst_ula_b", ula_b, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;

        //     name     op        A             B             sh     data          flag  lat eoc bp
        do_op("add",   5'b00000, 32'd1,        32'd2,        5'd7,  32'd3,        1'b0, 2,  1,  0);
        do_op("lsl3",  5'b01000, 32'd5,        32'd0,        5'd3,  32'h28,       1'b0, 4,  3,  0);
        do_op("asr1",  5'b01001, 32'h80000005, 32'd0,        5'd1,  32'hC0000002, 1'b0, 2,  1,  0);
        do_op("asr31", 5'b01001, 32'h80000000, 32'd0,        5'd31, 32'hFFFFFFFF, 1'b0, 32, 31, 0);
        do_op("lsl0",  5'b01000, 32'h1234,     32'd9,        5'd0,  32'h1234,     1'b0, 1,  0,  0);
        do_op("lsl_lost", 5'b01000, 32'h80000001, 32'd0,     5'd1,  32'h2,        1'b0, 2,  1,  0);
        do_op("lsl31", 5'b01000, 32'hFFFFFFFF, 32'd0,        5'd31, 32'h80000000, 1'b0, 32, 31, 0);
        do_op("asr_pos", 5'b01001, 32'h7FFFFFFF, 32'd0,      5'd30, 32'd1,        1'b0, 31, 30, 0);
        do_op("xor_zero", 5'b10110, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd3, 32'd0,     1'b1, 2,  1,  0);
        do_op("xor_bp", 5'b10110, 32'd2,       32'hFFFFFFFE, 5'd0,  32'hFFFFFFFC, 1'b0, 2,  1,  5);
        do_op("add2",  5'b00000, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 2,  1,  0);

        // Reset in the middle of a long shift: the result must never appear.
        @(negedge clk);
        req_op    = 5'b01000;
        req_a     = 32'd1;
        req_b     = 32'd0;
        req_shamt = 5'd20;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_shift_busy", {31'd0, busy}, 32'd1);
        check("mid_shift_opcode", {27'd0, ula_opcode}, 32'h08);
        reset     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rsp_data", rsp_data, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ula_opcode", {27'd0, ula_opcode}, 32'h10);
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_op("add_after", 5'b00000, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 2, 1, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
# ula_seq

Multi-cycle initiator for the combinational ULA. Accepts one operation request over a valid/ready handshake, drives the ULA operand and opcode inputs, and registers the result. Shift opcodes (LSL 01000, ASR 01001) move one bit per ULA pass, so this block iterates them for an N-bit shift. It sits between the control unit and the ULA and returns results over a second valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width
- CW, 5, shift-count width (max count 2^CW-1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  5  ULA opcode
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_shamt  in  CW  shift count; used only for 01000/01001
- ula_a  out  WIDTH  to ULA A
- ula_b  out  WIDTH  to ULA B
- ula_opcode  out  5  to ULA opcode
- ula_out  in  WIDTH  from ULA Out
- ula_flag  in  1  from ULA Flag
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  result
- rsp_flag  out  1  ULA flag of the final pass
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, SHIFT, RESP.
- Registers: op_r, a_r/acc, b_r, cnt (CW bits), rsp_data, rsp_flag.
- IDLE:
  - req_ready=1, so accept when req_valid.
  - On accept, latch req_op/req_a/req_b/req_shamt.
  - Shift op with shamt=0: rsp_data<=req_a, rsp_flag<=0, go to RESP.
  - Shift op with shamt>0: acc<=req_a, cnt<=shamt, go to SHIFT.
  - Any other op: go to EXEC.
- EXEC:
  - Drive ula_a=a_r, ula_b=b_r, ula_opcode=op_r.
  - Next edge: rsp_data<=ula_out, rsp_flag<=ula_flag, go to RESP.
- SHIFT:
  - Drive ula_a=acc, ula_b=b_r, ula_opcode=op_r.
  - Each edge: acc<=ula_out, cnt<=cnt-1.
  - When cnt==1: rsp_data<=ula_out, rsp_flag<=ula_flag, go to RESP.
  - Result equals A<<N for LSL and arithmetic A>>>N for ASR. Bits shifted out are lost; no wrap-around.
- RESP:
  - rsp_valid=1, with rsp_data/rsp_flag held stable.
  - On rsp_ready, go to IDLE.
- ULA drive outside EXEC/SHIFT: ula_a=0, ula_b=0, ula_opcode=5'b10000 (Out=0). The ULA inputs never carry a stale operation.
- req_ready=1 only in IDLE. No request is accepted in the same cycle a response completes, so a new request is taken at the earliest one cycle after the rsp handshake.
- Reset (any state, including mid-SHIFT or mid-RESP): next edge state=IDLE, rsp_valid=0, rsp_data=0, rsp_flag=0, acc/cnt/op_r cleared. An in-flight result is discarded. While reset is high, req_valid is ignored.

## Timing
- Reset values: req_ready=1 after the first reset edge; rsp_valid=0; rsp_data=0; rsp_flag=0; busy=0; ula_opcode=10000; ula_a=ula_b=0.
- Request accepted at edge T (req_valid && req_ready).
- Non-shift op: EXEC in cycle T..T+1, rsp_valid high after edge T+2. Latency 2.
- Shift op, shamt N>0: SHIFT occupies N cycles, rsp_valid high after edge T+1+N. Latency N+1; max 32 with CW=5.
- Shift op, shamt 0: rsp_valid high after edge T+1.
- rsp_valid stays high until a cycle with rsp_ready=1; it deasserts at that edge. Throughput is at most one op per latency+1 cycles.
- req_* are sampled only at the accepting edge; later changes have no effect.

## Test plan
- Add: req_op=00000, A=1, B=2, rsp_ready=1 -> rsp_data=3, rsp_valid exactly 2 cycles after accept, one cycle wide.
- LSL by 3: op=01000, A=5, shamt=3 -> rsp_data=40 (0x28) after 4 cycles; ula_opcode=01000 for exactly 3 cycles.
- ASR extremes:
  - op=01001, A=0x80000005, shamt=1 -> 0xC0000002.
  - A=0x80000000, shamt=31 -> 0xFFFFFFFF, rsp_valid after 32 cycles.
- Shamt 0: op=01000, A=0x1234, shamt=0 -> rsp_data=0x1234, rsp_flag=0, rsp_valid 1 cycle after accept; ULA never driven with 01000.
- Backpressure: XOR (10110) A=2, B=0xFFFFFFFE, rsp_ready low 5 cycles -> rsp_data=0xFFFFFFFC held stable; req_ready=0 throughout; second request accepted only the cycle after the rsp_ready handshake.
- Reset mid-shift: LSL A=1, shamt=20, assert reset at cycle 6 of SHIFT -> next edge rsp_valid=0, rsp_data=0, busy=0, ula_opcode=10000; no response for the aborted op. A following add 1+1 returns 2.
